// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Holds the last result in output registers and signals completion with a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int IN_W = 32,
  parameter int DIG  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   bin,
  output logic              busy,
  output logic              done,
  output logic [4*DIG-1:0]  bcd,
  output logic [3:0]        out_one,
  output logic [3:0]        out_ten,
  output logic              over99
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [4*DIG-1:0] scr_q, scr_adj, scr_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, over99_q;
  logic [4*DIG-1:0] bcd_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIG; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_d = {scr_adj[4*DIG-2:0], bin_q[IN_W-1]};
    bin_d = {bin_q[IN_W-2:0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      over99_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin;
            scr_q   <= '0;
            cnt_q   <= CW'(IN_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q    <= scr_d;
            over99_q <= |scr_d[4*DIG-1:8];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign over99  = over99_q;
  assign out_one = bcd_q[3:0];
  assign out_ten = bcd_q[7:4];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: latency, handshake, hold, back-to-back and async reset.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy, done, over99;
  logic [39:0] bcd;
  logic [3:0]  out_one, out_ten;

  int n_vec  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.IN_W(32), .DIG(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .out_one (out_one),
    .out_ten (out_ten),
    .over99  (over99)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one conversion, wait (bounded) for done, and check the result and handshake timing.
  task automatic convert(input string tag, input logic [31:0] v,
                         input logic [39:0] exp_bcd, input logic exp_ov);
    int lat, bc;
    bit got;
    bin = v; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bc = 0; got = 0;
    while (!got && lat < 40) begin
      if (busy) bc++;
      if (done) got = 1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, " latency"},   64'(lat), 64'd32);
    check({tag, " busy_cyc"},  64'(bc), 64'd32);
    check({tag, " bcd"},       64'(bcd), 64'(exp_bcd));
    check({tag, " out_ten"},   64'(out_ten), 64'(exp_bcd[7:4]));
    check({tag, " out_one"},   64'(out_one), 64'(exp_bcd[3:0]));
    check({tag, " over99"},    64'(over99), 64'(exp_ov));
    tick();
    check({tag, " done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int c, n_done, c_done, t, n;
    int d [2];

    rst = 1'b1; start = 1'b0; bin = '0;
    #1;
    check("rst busy",   64'(busy), 64'd0);
    check("rst done",   64'(done), 64'd0);
    check("rst bcd",    64'(bcd), 64'd0);
    check("rst over99", 64'(over99), 64'd0);
    #13 rst = 1'b0;
    tick();

    convert("zero", 32'd0, 40'h0, 1'b0);
    convert("d99", 32'd99, 40'h99, 1'b0);
    convert("d100", 32'd100, 40'h100, 1'b1);
    convert("max", 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b1);

    // start pulse while busy must be ignored; bcd holds the old value until the done edge
    bin = 32'd37; start = 1'b1;
    tick();
    start = 1'b0;
    c = 0; n_done = 0; c_done = 0;
    for (int i = 0; i < 70; i++) begin
      if (c == 9) begin bin = 32'd88; start = 1'b1; end
      tick();
      c++;
      start = 1'b0;
      if (done) begin
        n_done++;
        c_done = c;
      end else if (c == 10 || c == 31) begin
        check("busy_ign hold", 64'(bcd), 64'h42_9496_7295);
      end
    end
    check("busy_ign ndone", 64'(n_done), 64'd1);
    check("busy_ign cycle", 64'(c_done), 64'd32);
    check("busy_ign bcd",   64'(bcd), 64'h37);

    // back-to-back with start held high
    bin = 32'd12; start = 1'b1;
    tick();
    t = 0; n = 0; d[0] = 0; d[1] = 0;
    while (n < 2 && t < 80) begin
      tick();
      t++;
      if (done) begin
        d[n] = t;
        if (n == 0) begin
          check("b2b bcd1", 64'(bcd), 64'h12);
          bin = 32'd45;
        end else begin
          check("b2b bcd2", 64'(bcd), 64'h45);
          start = 1'b0;
        end
        n++;
      end
    end
    start = 1'b0;
    check("b2b ndone", 64'(n), 64'd2);
    check("b2b first", 64'(d[0]), 64'd32);
    check("b2b gap",   64'(d[1] - d[0]), 64'd33);
    tick();

    // async reset mid-conversion
    convert("pre_rst", 32'd12345, 40'h1_2345, 1'b1);
    bin = 32'd77; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst busy",   64'(busy), 64'd0);
    check("arst done",   64'(done), 64'd0);
    check("arst bcd",    64'(bcd), 64'd0);
    check("arst over99", 64'(over99), 64'd0);
    #1 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
    end
    check("arst no_done", 64'(n_done), 64'd0);
    convert("post_rst", 32'd58, 40'h58, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the four-digit seven-segment display driver. It converts a captured binary operand or result into decimal digits that feed the driver's tens/ones digit inputs.
- Results are held in an output register, so the display sees stable digits between conversions.
- Start/busy/done handshake toward the datapath that supplies the values.

Parameters:
- IN_W, 32, width of binary input in bits.
- DIG, 10, number of BCD digits produced. Must satisfy 10^DIG > 2^IN_W - 1. Default covers the full 32-bit range.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  conversion request; sampled on a rising clk edge when idle.
- bin  input  IN_W  binary value; sampled only on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new result registers are valid.
- bcd  output  4*DIG  registered packed BCD result; digit 0 (ones) is in bits [3:0].
- out_one  output  4  equals bcd[3:0]; feeds the display's ones digit.
- out_ten  output  4  equals bcd[7:4]; feeds the display's tens digit.
- over99  output  1  registered; 1 when the last converted value was greater than 99 (upper digits nonzero).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset value while rst=1, and immediately on assertion:
  - state=IDLE, busy=0, done=0, bcd=0, over99=0.
  - Internal shift register and bit counter cleared.
- States: IDLE, SHIFT.
- IDLE:
  - If start=1 at an edge, load bin into the binary shift register, clear the BCD scratch register, set the counter to IN_W, set busy=1, and go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3; digits are adjusted independently and in parallel.
  - Then shift {scratch, binary} left by 1 and decrement the counter.
- On the edge performing the last shift (counter 1 -> 0):
  - bcd <= final scratch value.
  - over99 <= (final digits 2..DIG-1 not all zero).
  - done <= 1, busy <= 0, state -> IDLE.
- done is high for exactly one cycle; it is 0 in all other cycles.
- Latency: start accepted at edge k gives busy=1 after edge k. The last shift occurs at edge k+IN_W, so done=1 and new bcd are visible after edge k+IN_W (32 cycles by default).
- Throughput: a start presented in the cycle where done=1 is accepted on the next edge. Back-to-back conversions therefore run every IN_W+1 cycles.
- start while busy=1 is ignored: no queuing, no restart, bin not resampled.
- bin changes during a conversion have no effect.
- bcd, out_one, out_ten and over99 hold the previous result throughout a conversion and change only on the done edge.
- out_one and out_ten are continuous assigns from bcd; they add no extra latency.
- Reset mid-conversion aborts it: outputs go to reset values, and no done pulse occurs afterwards.
- Counter width: clog2(IN_W+1).
- The scratch register is 4*DIG bits. With a valid DIG no carry out of the top digit is possible, so none is tracked.

Test Plan:
- Reset, then start with bin=0 -> done after 32 cycles; bcd=0, out_ten=0, out_one=0, over99=0; busy high exactly 32 cycles.
- bin=99 -> out_ten=9, out_one=9, over99=0. Then bin=100 -> bcd=0x...100, out_ten=0, out_one=0, over99=1.
- bin=32'hFFFFFFFF -> bcd=40'h4294967295, over99=1. Done pulse width is exactly 1 cycle.
- Start bin=37, then pulse start with bin=88 at cycle 10 while busy -> single done at cycle 32 with result 37. bcd must hold its old value until that edge.
- Back-to-back: assert start with bin=12 held high continuously, then change bin to 45 in the done cycle -> second conversion accepted on the edge after done; result 45; two done pulses 33 cycles apart.
- Assert rst asynchronously (mid-cycle) at cycle 15 of a conversion -> busy, done, bcd and over99 go to 0 immediately. No done pulse follows; the next start converts normally.
